// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types for the multi-cycle sequencing controller
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'b00,
    ERR_ILLEGAL      = 2'b01,
    ERR_IMEM_TIMEOUT = 2'b10,
    ERR_DMEM_TIMEOUT = 2'b11
  } err_code_t;

  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait counter flagging a memory request that never completes
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !ready_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Fault fires in the waiting cycle that would bring the count to the limit; ready in that cycle wins.
  assign timeout_o = enable_i && !ready_i && (count_q >= LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with memory watchdog
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       is_branch_i,
  input  logic       is_jal_i,
  input  logic       is_jalr_i,
  input  logic       is_load_i,
  input  logic       is_store_i,
  input  logic       reg_write_i,
  input  logic       illegal_i,
  input  logic       branch_taken_i,
  output logic       imem_req_o,
  input  logic       imem_ready_i,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_ready_i,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_sel_o,
  output logic       rf_write_o,
  output logic       retire_o,
  output logic [2:0] state_o,
  output logic       halted_o,
  output logic [1:0] err_code_o
);

  ctrl_state_t state_q, state_d;
  err_code_t   err_q, err_d;
  pc_sel_t     pc_sel;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_ready;
  logic        timeout;

  assign timer_enable = is_wait_state(state_q);
  assign timer_ready  = (state_q == MEM) ? dmem_ready_i : imem_ready_i;
  assign timer_clear  = (state_d != state_q) && is_wait_state(state_d);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear),
    .enable_i (timer_enable),
    .ready_i  (timer_ready),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    pc_sel     = PC_PLUS4;
    rf_write_o = 1'b0;
    retire_o   = 1'b0;
    halted_o   = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_write_o = 1'b1;
          state_d    = DECODE;
        end else if (timeout) begin
          state_d = HALT;
          err_d   = ERR_IMEM_TIMEOUT;
        end
      end

      DECODE: begin
        if (illegal_i) begin
          state_d = HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = EXECUTE;
        end
      end

      EXECUTE: begin
        if (is_load_i || is_store_i) begin
          state_d = MEM;
        end else if (is_branch_i) begin
          pc_write_o = 1'b1;
          pc_sel     = branch_taken_i ? PC_BRANCH : PC_PLUS4;
          retire_o   = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end

      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store_i;
        if (dmem_ready_i) begin
          // Store wins over load when both flags are set: it retires here with no writeback.
          if (is_store_i) begin
            pc_write_o = 1'b1;
            retire_o   = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (timeout) begin
          state_d = HALT;
          err_d   = ERR_DMEM_TIMEOUT;
        end
      end

      WRITEBACK: begin
        rf_write_o = reg_write_i;
        pc_write_o = 1'b1;
        pc_sel     = is_jal_i ? PC_JAL : (is_jalr_i ? PC_JALR : PC_PLUS4);
        retire_o   = 1'b1;
        state_d    = FETCH;
      end

      HALT: halted_o = 1'b1;

      default: state_d = HALT;
    endcase
  end

  assign pc_sel_o   = pc_sel;
  assign state_o    = state_q;
  assign err_code_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [2:0] S_ID = 3'd0, S_FE = 3'd1, S_DE = 3'd2, S_EX = 3'd3;
  localparam logic [2:0] S_ME = 3'd4, S_WB = 3'd5, S_HA = 3'd6;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       is_branch_i = 0, is_jal_i = 0, is_jalr_i = 0, is_load_i = 0, is_store_i = 0;
  logic       reg_write_i = 0, illegal_i = 0, branch_taken_i = 0;
  logic       imem_ready_i = 0, dmem_ready_i = 0;
  logic       imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o;
  logic       rf_write_o, retire_o, halted_o;
  logic [1:0] pc_sel_o, err_code_o;
  logic [2:0] state_o;

  int checks = 0;
  int passed = 0;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .reg_write_i(reg_write_i),
    .illegal_i(illegal_i), .branch_taken_i(branch_taken_i),
    .imem_req_o(imem_req_o), .imem_ready_i(imem_ready_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_sel_o(pc_sel_o),
    .rf_write_o(rf_write_o), .retire_o(retire_o), .state_o(state_o),
    .halted_o(halted_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1);
  end

  // {state, imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, rf_write, retire, halted, err}
  function automatic logic [14:0] obs();
    return {state_o, imem_req_o, ir_write_o, dmem_req_o, dmem_we_o, pc_write_o,
            pc_sel_o, rf_write_o, retire_o, halted_o, err_code_o};
  endfunction

  // Row = {imem_ready stimulus, dmem_ready stimulus, expected observation}
  function automatic logic [16:0] row(input logic imr, input logic dmr, input logic [2:0] st,
                                      input logic ireq, input logic irw, input logic dreq,
                                      input logic dwe, input logic pcw, input logic [1:0] sel,
                                      input logic rfw, input logic ret, input logic hlt,
                                      input logic [1:0] err);
    return {imr, dmr, st, ireq, irw, dreq, dwe, pcw, sel, rfw, ret, hlt, err};
  endfunction

  task automatic set_flags(input logic br, input logic jal, input logic jalr, input logic ld,
                           input logic st, input logic rw, input logic ill, input logic tk);
    is_branch_i = br; is_jal_i = jal; is_jalr_i = jalr; is_load_i = ld;
    is_store_i = st; reg_write_i = rw; illegal_i = ill; branch_taken_i = tk;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs() !== 15'd0) $display("FAIL reset_hold got %h expected %h", obs(), 15'd0);
    else passed++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    checks++;
    if (obs() !== {S_ID, 12'd0}) $display("FAIL reset_release_idle got %h expected %h", obs(), {S_ID, 12'd0});
    else passed++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_addi();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 0, 0, 1, 0, 0);
    rows = '{row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_WB,0,0,0,0,1,2'b00,1,1,0,2'b00)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL addi[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_lw();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 1, 0, 1, 0, 0);
    rows = '{row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,1,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_WB,0,0,0,0,1,2'b00,1,1,0,2'b00)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL lw[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_branch(input logic taken);
    logic [16:0] rows [$];
    logic [1:0]  sel;
    sel = taken ? 2'b01 : 2'b00;
    set_flags(1, 0, 0, 0, 0, 0, 0, taken);
    rows = '{row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,1,sel,  0,1,0,2'b00)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL branch_taken%0d[%0d] got %h expected %h", taken, i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_jalr();
    logic [16:0] rows [$];
    set_flags(0, 0, 1, 0, 0, 1, 0, 0);
    rows = '{row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_WB,0,0,0,0,1,2'b11,1,1,0,2'b00)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL jalr[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_sw();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 0, 1, 0, 0, 0);
    rows = '{row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,1,0,2'b00,0,0,0,2'b00),
             row(0,1,S_ME,0,0,1,1,1,2'b00,0,1,0,2'b00)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL sw[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_reset_mid_mem();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 1, 0, 1, 0, 0);
    rows = '{row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL mid_mem_pre[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0) $display("FAIL mid_mem_async_req got %b expected 0", dmem_req_o);
    else passed++;
    checks++;
    if (state_o !== S_ID) $display("FAIL mid_mem_async_state got %0d expected %0d", state_o, S_ID);
    else passed++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    checks++;
    if (obs() !== {S_ID, 12'd0}) $display("FAIL mid_mem_idle got %h expected %h", obs(), {S_ID, 12'd0});
    else passed++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_fetch_last_ready_illegal();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 0, 0, 1, 1, 0);
    rows = '{row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_HA,0,0,0,0,0,2'b00,0,0,1,2'b01),
             row(1,1,S_HA,0,0,0,0,0,2'b00,0,0,1,2'b01)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL fetch_last_illegal[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_imem_timeout();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    rows = '{row(0,0,S_ID,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_FE,1,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_HA,0,0,0,0,0,2'b00,0,0,1,2'b10),
             row(1,0,S_HA,0,0,0,0,0,2'b00,0,0,1,2'b10)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL imem_timeout[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  task automatic test_dmem_timeout();
    logic [16:0] rows [$];
    set_flags(0, 0, 0, 1, 0, 1, 0, 0);
    do_reset();
    rows = '{row(0,0,S_ID,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(1,0,S_FE,1,1,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_DE,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_EX,0,0,0,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_ME,0,0,1,0,0,2'b00,0,0,0,2'b00),
             row(0,0,S_HA,0,0,0,0,0,2'b00,0,0,1,2'b11)};
    foreach (rows[i]) begin
      imem_ready_i = rows[i][16]; dmem_ready_i = rows[i][15]; #1;
      checks++;
      if (obs() !== rows[i][14:0]) $display("FAIL dmem_timeout[%0d] got %h expected %h", i, obs(), rows[i][14:0]);
      else passed++;
      @(posedge clk_i); #1;
    end
    imem_ready_i = 0; dmem_ready_i = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jalr();
    test_sw();
    test_reset_mid_mem();
    test_fetch_last_ready_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
